// File: rtl/clock_pkg.sv
// Shared types and constants for the 12-hour clock: mode enum, default timing,
// and button indices used by the controller, time datapath and scanner.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_MIN = 2'd1,
    SET_HR  = 2'd2
  } mode_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_REPEAT_DELAY    = 50000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 25000000;
  localparam int unsigned DEF_BLINK_HALF      = 25000000;

  localparam int unsigned BTN_CENTER = 0;
  localparam int unsigned BTN_LEFT   = 1;
  localparam int unsigned BTN_RIGHT  = 2;
  localparam int unsigned BTN_UP     = 3;
  localparam int unsigned BTN_DOWN   = 4;
  localparam int unsigned NUM_BTN    = 5;

  // Counter width wide enough for the largest timing constant, plus one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, counter debounce and registered press pulse for one button.
module btn_debounce import clock_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic             r_armed;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;
  logic             w_done;

  assign w_differ = r_sync2 ^ r_level;
  assign w_done   = (r_cnt >= CNT_W'(DEBOUNCE_CYCLES - 1));

  // Synchroniser resets high so a button held through reset is never armed;
  // it must be seen released before its next rising edge counts as a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_armed <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (!r_sync2) r_armed <= 1'b1;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_level <= r_sync2;
        r_rise  <= r_sync2 & r_armed;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/clock_set_ctrl.sv
// Push-button user interface for the 12-hour clock: mode FSM, set commands with
// auto-repeat, clear-on-enter-set, and field blink blanking.
module clock_set_ctrl import clock_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned BLINK_HALF      = DEF_BLINK_HALF
) (
  input  logic clk,
  input  logic rst,
  input  logic center,
  input  logic left,
  input  logic right,
  input  logic up,
  input  logic down,
  output logic run_en,
  output logic clr_sub,
  output logic inc_min,
  output logic dec_min,
  output logic inc_hr,
  output logic dec_hr,
  output logic blank_min,
  output logic blank_hr,
  output logic clk_mode_led
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY,
                                            REPEAT_PERIOD, BLINK_HALF);

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_rise;
  logic               w_unused_lvl;

  assign w_raw[BTN_CENTER] = center;
  assign w_raw[BTN_LEFT]   = left;
  assign w_raw[BTN_RIGHT]  = right;
  assign w_raw[BTN_UP]     = up;
  assign w_raw[BTN_DOWN]   = down;
  assign w_unused_lvl = &{w_level[BTN_CENTER], w_level[BTN_LEFT], w_level[BTN_RIGHT]};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .i_btn  (w_raw[g]),
      .o_level(w_level[g]),
      .o_rise (w_rise[g])
    );
  end

  mode_e            r_state, w_state_nxt;
  logic [CNT_W-1:0] r_rep_cnt, w_rep_cnt_nxt, w_rep_thr;
  logic [CNT_W-1:0] r_blink_cnt, w_blink_cnt_nxt;
  logic             r_rep_act, w_rep_act_nxt;
  logic             r_rep_up, w_rep_up_nxt;
  logic             r_rep_first, w_rep_first_nxt;
  logic             r_blink_on, w_blink_on_nxt;
  logic             w_rep_hold, w_inc, w_dec, w_clr;
  logic             r_run_en, r_clr_sub, r_inc_min, r_dec_min, r_inc_hr, r_dec_hr;
  logic             r_blank_min, r_blank_hr;

  always_ff @(posedge clk) begin
    if (rst) r_state <= SET_MIN;
    else     r_state <= w_state_nxt;
  end

  // Next state, command, repeat and blink decisions; priority center > left/right > up/down.
  always_comb begin
    w_state_nxt     = r_state;
    w_clr           = 1'b0;
    w_inc           = 1'b0;
    w_dec           = 1'b0;
    w_rep_act_nxt   = 1'b0;
    w_rep_up_nxt    = r_rep_up;
    w_rep_first_nxt = r_rep_first;
    w_rep_cnt_nxt   = '0;
    w_blink_on_nxt  = 1'b1;
    w_blink_cnt_nxt = '0;
    w_rep_thr       = r_rep_first ? CNT_W'(REPEAT_DELAY - 1) : CNT_W'(REPEAT_PERIOD - 1);
    w_rep_hold      = r_rep_up ? w_level[BTN_UP] : w_level[BTN_DOWN];

    if (w_rise[BTN_CENTER]) begin
      if (r_state == RUN) begin
        w_state_nxt = SET_MIN;
        w_clr       = 1'b1;
      end else begin
        w_state_nxt = RUN;
      end
    end else if (r_state != RUN) begin
      if (w_rise[BTN_LEFT] | w_rise[BTN_RIGHT]) begin
        w_state_nxt = (r_state == SET_MIN) ? SET_HR : SET_MIN;
      end else if (w_level[BTN_UP] & w_level[BTN_DOWN]) begin
        w_rep_act_nxt = 1'b0;
      end else if (w_rise[BTN_UP] | w_rise[BTN_DOWN]) begin
        w_inc           = w_rise[BTN_UP];
        w_dec           = ~w_rise[BTN_UP];
        w_rep_act_nxt   = 1'b1;
        w_rep_up_nxt    = w_rise[BTN_UP];
        w_rep_first_nxt = 1'b1;
      end else if (r_rep_act & w_rep_hold) begin
        w_rep_act_nxt = 1'b1;
        if (r_rep_cnt >= w_rep_thr) begin
          w_inc           = r_rep_up;
          w_dec           = ~r_rep_up;
          w_rep_first_nxt = 1'b0;
        end else begin
          w_rep_cnt_nxt = r_rep_cnt + CNT_W'(1);
        end
      end
    end

    if ((w_state_nxt != RUN) && (w_state_nxt == r_state) && !w_inc && !w_dec) begin
      if (r_blink_cnt >= CNT_W'(BLINK_HALF - 1)) begin
        w_blink_on_nxt = ~r_blink_on;
      end else begin
        w_blink_on_nxt  = r_blink_on;
        w_blink_cnt_nxt = r_blink_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep_cnt   <= '0;
      r_rep_act   <= 1'b0;
      r_rep_up    <= 1'b0;
      r_rep_first <= 1'b0;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
      r_run_en    <= 1'b0;
      r_clr_sub   <= 1'b0;
      r_inc_min   <= 1'b0;
      r_dec_min   <= 1'b0;
      r_inc_hr    <= 1'b0;
      r_dec_hr    <= 1'b0;
      r_blank_min <= 1'b0;
      r_blank_hr  <= 1'b0;
    end else begin
      r_rep_cnt   <= w_rep_cnt_nxt;
      r_rep_act   <= w_rep_act_nxt;
      r_rep_up    <= w_rep_up_nxt;
      r_rep_first <= w_rep_first_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_blink_on  <= w_blink_on_nxt;
      r_run_en    <= (w_state_nxt == RUN);
      r_clr_sub   <= w_clr;
      r_inc_min   <= w_inc & (r_state == SET_MIN);
      r_dec_min   <= w_dec & (r_state == SET_MIN);
      r_inc_hr    <= w_inc & (r_state == SET_HR);
      r_dec_hr    <= w_dec & (r_state == SET_HR);
      r_blank_min <= (w_state_nxt == SET_MIN) & ~w_blink_on_nxt;
      r_blank_hr  <= (w_state_nxt == SET_HR) & ~w_blink_on_nxt;
    end
  end

  assign run_en       = r_run_en;
  assign clk_mode_led = r_run_en;
  assign clr_sub      = r_clr_sub;
  assign inc_min      = r_inc_min;
  assign dec_min      = r_dec_min;
  assign inc_hr       = r_inc_hr;
  assign dec_hr       = r_dec_hr;
  assign blank_min    = r_blank_min;
  assign blank_hr     = r_blank_hr;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short timing constants.
module tb_clock_set_ctrl;
  import clock_pkg::*;

  logic       clk;
  logic       rst;
  logic [4:0] btns;
  logic run_en, clr_sub, inc_min, dec_min, inc_hr, dec_hr, blank_min, blank_hr, clk_mode_led;

  int total, bad, cyc;
  int n_inc_min, n_dec_min, n_inc_hr, n_dec_hr, n_clr, n_blank_min, n_blank_hr, n_multi;
  int inc_min_t[$];
  int rep_offs [7] = '{0, 20, 28, 36, 44, 52, 60};
  int t, m;

  clock_set_ctrl #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .BLINK_HALF(16)
  ) dut (
    .clk(clk), .rst(rst),
    .center(btns[BTN_CENTER]), .left(btns[BTN_LEFT]), .right(btns[BTN_RIGHT]),
    .up(btns[BTN_UP]), .down(btns[BTN_DOWN]),
    .run_en(run_en), .clr_sub(clr_sub), .inc_min(inc_min), .dec_min(dec_min),
    .inc_hr(inc_hr), .dec_hr(dec_hr), .blank_min(blank_min), .blank_hr(blank_hr),
    .clk_mode_led(clk_mode_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (inc_min) begin n_inc_min++; inc_min_t.push_back(cyc); end
    if (dec_min) n_dec_min++;
    if (inc_hr) n_inc_hr++;
    if (dec_hr) n_dec_hr++;
    if (clr_sub) n_clr++;
    if (blank_min) n_blank_min++;
    if (blank_hr) n_blank_hr++;
    if ((int'(inc_min) + int'(dec_min) + int'(inc_hr) + int'(dec_hr) + int'(clr_sub)) > 1)
      n_multi++;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic clear_counts();
    n_inc_min = 0; n_dec_min = 0; n_inc_hr = 0; n_dec_hr = 0;
    n_clr = 0; n_blank_min = 0; n_blank_hr = 0;
    inc_min_t.delete();
  endtask

  task automatic press(input int idx, input int hold);
    btns[idx] = 1'b1;
    repeat (hold) tick();
    btns[idx] = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; n_multi = 0;
    rst = 1'b1; btns = '0;
    clear_counts();
    repeat (3) tick();
    chk("reset_outs", 32'({run_en, clr_sub, inc_min, dec_min, inc_hr, dec_hr,
                           blank_min, blank_hr, clk_mode_led}), 32'd0);
    rst = 1'b0;
    repeat (8) tick();
    clear_counts();

    // Short pulses and a glitch never reach the debounced level.
    btns[BTN_UP] = 1'b1; tick(); btns[BTN_UP] = 1'b0; repeat (8) tick();
    btns[BTN_UP] = 1'b1; repeat (3) tick(); btns[BTN_UP] = 1'b0; repeat (8) tick();
    btns[BTN_UP] = 1'b1; repeat (2) tick(); btns[BTN_UP] = 1'b0; tick();
    btns[BTN_UP] = 1'b1; repeat (2) tick(); btns[BTN_UP] = 1'b0; repeat (8) tick();
    chk("glitch_inc", n_inc_min, 0);

    t = cyc;
    btns[BTN_UP] = 1'b1; repeat (10) tick(); btns[BTN_UP] = 1'b0; repeat (10) tick();
    chk("single_inc", n_inc_min, 1);
    if (inc_min_t.size() > 0) chk("press_latency", inc_min_t[0] - t, 7);
    clear_counts();

    // Auto-repeat: first pulse at t+7, then +20 and every 8 after.
    t = cyc;
    btns[BTN_UP] = 1'b1;
    wait_cyc(t + 67);
    btns[BTN_UP] = 1'b0;
    repeat (40) tick();
    chk("rep_count", inc_min_t.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < inc_min_t.size()) chk("rep_time", inc_min_t[i] - t, 7 + rep_offs[i]);
    chk("rep_other", n_dec_min + n_inc_hr + n_dec_hr, 0);
    clear_counts();

    // Mode walk: SET_MIN -> SET_HR -> RUN -> SET_MIN.
    press(BTN_RIGHT, 8);
    press(BTN_DOWN, 8);
    chk("dec_hr", n_dec_hr, 1);
    chk("dec_min_none", n_dec_min, 0);
    press(BTN_CENTER, 8);
    chk("run_en_on", 32'(run_en), 32'd1);
    chk("led_on", 32'(clk_mode_led), 32'd1);
    chk("no_clr_leaving_set", n_clr, 0);
    clear_counts();
    press(BTN_CENTER, 8);
    chk("clr_pulse", n_clr, 1);
    chk("run_en_off", 32'(run_en), 32'd0);
    press(BTN_UP, 8);
    chk("back_in_set_min", n_inc_min, 1);
    clear_counts();

    // Center beats up on the same cycle; up+down together issue nothing.
    btns[BTN_CENTER] = 1'b1; btns[BTN_UP] = 1'b1;
    repeat (8) tick();
    btns[BTN_CENTER] = 1'b0; btns[BTN_UP] = 1'b0;
    repeat (10) tick();
    chk("center_prio_run", 32'(run_en), 32'd1);
    chk("center_prio_noinc", n_inc_min, 0);
    press(BTN_CENTER, 8);
    clear_counts();
    btns[BTN_UP] = 1'b1; btns[BTN_DOWN] = 1'b1;
    repeat (100) tick();
    btns[BTN_UP] = 1'b0; btns[BTN_DOWN] = 1'b0;
    repeat (10) tick();
    chk("updown_cmds", n_inc_min + n_dec_min + n_inc_hr + n_dec_hr, 0);

    // Blink in SET_HR, measured from the mode change at m.
    t = cyc;
    m = t + 7;
    btns[BTN_RIGHT] = 1'b1;
    wait_cyc(m);
    clear_counts();
    wait_cyc(t + 8);
    btns[BTN_RIGHT] = 1'b0;
    wait_cyc(m + 15); chk("blink_m15", 32'(blank_hr), 32'd0);
    wait_cyc(m + 16); chk("blink_m16", 32'(blank_hr), 32'd1);
    wait_cyc(m + 31); chk("blink_m31", 32'(blank_hr), 32'd1);
    wait_cyc(m + 32); chk("blink_m32", 32'(blank_hr), 32'd0);
    wait_cyc(m + 48); chk("blink_m48", 32'(blank_hr), 32'd1);
    wait_cyc(m + 50);
    btns[BTN_UP] = 1'b1;
    wait_cyc(m + 56); chk("blink_pre_inc", 32'(blank_hr), 32'd1);
    wait_cyc(m + 57); chk("blink_inc_force", 32'(blank_hr), 32'd0);
    wait_cyc(m + 58);
    btns[BTN_UP] = 1'b0;
    wait_cyc(m + 72); chk("blink_hold_16", 32'(blank_hr), 32'd0);
    wait_cyc(m + 73); chk("blink_resume", 32'(blank_hr), 32'd1);
    chk("inc_hr_once", n_inc_hr, 1);
    chk("blank_min_in_hr", n_blank_min, 0);

    press(BTN_CENTER, 8);
    clear_counts();
    repeat (40) tick();
    chk("run_blanks", n_blank_min + n_blank_hr, 0);
    chk("run_en_blinktest", 32'(run_en), 32'd1);

    // Reset in the middle of a held auto-repeat.
    press(BTN_CENTER, 8);
    clear_counts();
    t = cyc;
    btns[BTN_UP] = 1'b1;
    wait_cyc(t + 29);
    chk("rep_before_rst", n_inc_min, 2);
    rst = 1'b1;
    tick();
    chk("rst_mid_outs", 32'({run_en, clr_sub, inc_min, dec_min, inc_hr, dec_hr,
                             blank_min, blank_hr, clk_mode_led}), 32'd0);
    tick();
    rst = 1'b0;
    clear_counts();
    repeat (60) tick();
    chk("held_after_rst", n_inc_min, 0);
    btns[BTN_UP] = 1'b0;
    repeat (10) tick();
    press(BTN_UP, 8);
    chk("repress_inc_min", n_inc_min, 1);
    chk("repress_inc_hr", n_inc_hr, 0);

    chk("one_cmd_per_cycle", n_multi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
